idma_backend_rr_scheduler: RTL and testbench

Shares one iDMA backend between `NumReq` independent frontends (register frontends, core-local request ports, and similar).
- Forwards transfer requests to the backend with round-robin arbitration.
- Records the owner of every accepted transfer in an in-order owner FIFO.
- Routes each backend completion pulse back to the requester that issued the transfer.
- Sits between the frontends and `idma_backend`; the backend itself is unchanged.

---
 rtl/idma_backend_rr_scheduler_if.sv | 27 ++
 rtl/idma_backend_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_idma_backend_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_backend_rr_scheduler_if.sv
// Handshake bundle between NumReq iDMA frontends, the shared backend and the
// round-robin scheduler that sits between them.
interface idma_backend_rr_scheduler_if #(
  parameter int  NumReq     = 4,
  parameter type idma_req_t = logic
);
  idma_req_t           req_i [NumReq];
  logic [NumReq-1:0]   req_valid_i;
  logic [NumReq-1:0]   req_ready_o;
  idma_req_t           be_req_o;
  logic                be_valid_o;
  logic                be_ready_i;
  logic                be_rsp_valid_i;
  logic                be_rsp_ready_o;
  logic [NumReq-1:0]   rsp_valid_o;
  logic [NumReq-1:0]   rsp_ready_i;

  modport master (
    input  req_i, req_valid_i, be_ready_i, be_rsp_valid_i, rsp_ready_i,
    output req_ready_o, be_req_o, be_valid_o, be_rsp_ready_o, rsp_valid_o
  );

  modport slave (
    output req_i, req_valid_i, be_ready_i, be_rsp_valid_i, rsp_ready_i,
    input  req_ready_o, be_req_o, be_valid_o, be_rsp_ready_o, rsp_valid_o
  );
endinterface

// File: rtl/idma_backend_rr_scheduler.sv
// Round-robin sharing of one iDMA backend; an in-order owner FIFO routes each
// completion pulse back to the frontend that issued the transfer.
module idma_backend_rr_scheduler #(
  parameter int  NumReq         = 4,
  parameter int  MaxOutstanding = 8,
  parameter type idma_req_t     = logic,
  parameter int  CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  idma_backend_rr_scheduler_if.master bus,
  output logic [CntWidth-1:0]         outstanding_o,
  output logic                        busy_o
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e              state_reg, state_next;
  logic [IdxW-1:0]     lock_idx_reg, lock_idx_next;
  logic [IdxW-1:0]     prio_reg;
  logic [PtrW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CntWidth-1:0] fill_reg;
  logic [IdxW-1:0]     owner_mem [MaxOutstanding];

  logic [IdxW-1:0]     scan_idx, rr_grant, grant, head;
  logic                rr_found, lock_hold, grant_valid, arb_en, be_valid;
  logic                push, pop, empty, be_rsp_ready;
  logic [NumReq-1:0]   req_ready, rsp_valid;
  idma_req_t           be_req;

  // First valid requester scanning upward from prio, wrapping modulo NumReq.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = IdxW'((int'(prio_reg) + k) % NumReq);
      if (!rr_found && bus.req_valid_i[scan_idx]) begin
        rr_grant = scan_idx;
        rr_found = 1'b1;
      end
    end
  end

  // A stalled grant stays frozen; if its owner drops valid the lock falls away.
  assign lock_hold   = (state_reg == ST_LOCKED) && bus.req_valid_i[lock_idx_reg];
  assign grant       = lock_hold ? lock_idx_reg : rr_grant;
  assign grant_valid = lock_hold || rr_found;
  assign arb_en      = (fill_reg != FullCnt);
  assign be_valid    = arb_en && grant_valid;
  assign push        = be_valid && bus.be_ready_i;

  assign empty        = (fill_reg == '0);
  assign head         = owner_mem[rd_ptr_reg];
  assign be_rsp_ready = !empty && bus.rsp_ready_i[head];
  assign pop          = bus.be_rsp_valid_i && be_rsp_ready;

  assign be_req = bus.req_i[grant];

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_route
      assign req_ready[gi] = push && (grant == IdxW'(gi));
      assign rsp_valid[gi] = bus.be_rsp_valid_i && !empty && (head == IdxW'(gi));
    end
  endgenerate

  assign bus.be_req_o       = be_req;
  assign bus.be_valid_o     = be_valid;
  assign bus.req_ready_o    = req_ready;
  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.be_rsp_ready_o = be_rsp_ready;
  assign outstanding_o      = fill_reg;
  assign busy_o             = !empty || be_valid;

  always_comb begin
    state_next    = ST_ARB;
    lock_idx_next = lock_idx_reg;
    if (be_valid && !bus.be_ready_i) begin
      state_next    = ST_LOCKED;
      lock_idx_next = grant;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_ARB;
      lock_idx_reg <= '0;
      prio_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      if (push) begin
        prio_reg   <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        fill_reg <= fill_reg + 1'b1;
      end else if (pop && !push) begin
        fill_reg <= fill_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      owner_mem[wr_ptr_reg] <= grant;
    end
  end

`ifndef SYNTHESIS
  lock_drop_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_reg == ST_LOCKED) |-> bus.req_valid_i[lock_idx_reg]);
  rsp_empty_a: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.be_rsp_valid_i |-> !empty);
`endif
endmodule

// File: tb/tb_idma_backend_rr_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based ownership model.
module tb_idma_backend_rr_scheduler;
  localparam int NREQ = 4;
  localparam int MAXO = 8;
  typedef logic [7:0] req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] outstanding;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  idma_backend_rr_scheduler_if #(.NumReq(NREQ), .idma_req_t(req_t)) bus ();

  idma_backend_rr_scheduler #(
    .NumReq(NREQ), .MaxOutstanding(MAXO), .idma_req_t(req_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .outstanding_o(outstanding), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner queue, next-priority index, frozen grant (-1 = none).
  int   m_q[$];
  int   m_prio = 0;
  int   m_lock = -1;
  int   e_grant;
  bit   e_bv, e_brr;
  logic [3:0] e_rdy, e_rspv;
  req_t pay [NREQ];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_eval();
    e_grant = -1;
    if (m_q.size() < MAXO) begin
      if (m_lock >= 0 && bus.req_valid_i[m_lock]) e_grant = m_lock;
      else begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_prio + k) % NREQ;
          if (e_grant < 0 && bus.req_valid_i[i]) e_grant = i;
        end
      end
    end
    e_bv   = (e_grant >= 0);
    e_rdy  = (e_bv && bus.be_ready_i) ? 4'(1 << e_grant) : 4'b0;
    e_rspv = 4'b0;
    e_brr  = 1'b0;
    if (m_q.size() > 0) begin
      e_brr = bus.rsp_ready_i[m_q[0]];
      if (bus.be_rsp_valid_i) e_rspv = 4'(1 << m_q[0]);
    end
  endfunction

  function automatic void model_check();
    chk("be_valid", int'(bus.be_valid_o), int'(e_bv));
    chk("req_ready", int'(bus.req_ready_o), int'(e_rdy));
    if (e_bv) chk("be_req", int'(bus.be_req_o), int'(pay[e_grant]));
    chk("rsp_valid", int'(bus.rsp_valid_o), int'(e_rspv));
    chk("be_rsp_ready", int'(bus.be_rsp_ready_o), int'(e_brr));
    chk("outstanding", int'(outstanding), m_q.size());
    chk("busy", int'(busy), int'(m_q.size() != 0 || e_bv));
  endfunction

  function automatic void model_update();
    bit do_pop;
    if (rst) begin
      m_q.delete();
      m_prio = 0;
      m_lock = -1;
      $display("reset: ownership discarded");
    end else begin
      do_pop = bus.be_rsp_valid_i && (m_q.size() > 0) && bus.rsp_ready_i[m_q[0]];
      if (do_pop) begin
        $display("completion -> requester %0d", m_q[0]);
        void'(m_q.pop_front());
      end
      if (e_bv && bus.be_ready_i) begin
        $display("accept requester %0d payload 0x%02h", e_grant, pay[e_grant]);
        m_q.push_back(e_grant);
        m_prio = (e_grant + 1) % NREQ;
        m_lock = -1;
      end else if (e_bv) m_lock = e_grant;
      else m_lock = -1;
    end
  endfunction

  task automatic drive(input logic [3:0] rv, input logic br, input logic rspv, input logic [3:0] rr);
    for (int i = 0; i < NREQ; i++) bus.req_i[i] = pay[i];
    bus.req_valid_i    = rv;
    bus.be_ready_i     = br;
    bus.be_rsp_valid_i = rspv;
    bus.rsp_ready_i    = rr;
  endtask

  task automatic eval_cycle();
    #4;
    model_eval();
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       br;
    logic       rspv;
    logic [3:0] rr;
    logic [3:0] x_rdy;
    logic       x_bv;
    logic [3:0] x_rspv;
    int         x_out;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] rv, input logic br, input logic rspv, input logic [3:0] rr,
                              input logic [3:0] x_rdy, input logic x_bv, input logic [3:0] x_rspv, input int x_out);
    vec_t v;
    v.rv = rv; v.br = br; v.rspv = rspv; v.rr = rr;
    v.x_rdy = x_rdy; v.x_bv = x_bv; v.x_rspv = x_rspv; v.x_out = x_out;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] rv;
    logic       br, rspv;
    logic [3:0] rr;

    for (int i = 0; i < NREQ; i++) pay[i] = req_t'(8'hA0 + i);
    drive(4'b0, 1'b0, 1'b0, 4'hF);

    // Round-robin 0,1,2,3,0,1 then drain in the same order, then single requester.
    add(4'hF, 1, 0, 4'hF, 4'b0001, 1, 4'b0000, 0);
    add(4'hF, 1, 0, 4'hF, 4'b0010, 1, 4'b0000, 1);
    add(4'hF, 1, 0, 4'hF, 4'b0100, 1, 4'b0000, 2);
    add(4'hF, 1, 0, 4'hF, 4'b1000, 1, 4'b0000, 3);
    add(4'hF, 1, 0, 4'hF, 4'b0001, 1, 4'b0000, 4);
    add(4'hF, 1, 0, 4'hF, 4'b0010, 1, 4'b0000, 5);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0001, 6);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0010, 5);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0100, 4);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b1000, 3);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0001, 2);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0010, 1);
    add(4'b0001, 1, 0, 4'hF, 4'b0001, 1, 4'b0000, 0);
    add(4'b0001, 1, 0, 4'hF, 4'b0001, 1, 4'b0000, 1);
    add(4'b0001, 1, 0, 4'hF, 4'b0001, 1, 4'b0000, 2);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0001, 3);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0001, 2);
    add(4'h0, 0, 1, 4'hF, 4'b0000, 0, 4'b0001, 1);
    add(4'h0, 0, 0, 4'hF, 4'b0000, 0, 4'b0000, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    eval_cycle();
    chk("reset_outstanding", int'(outstanding), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_be_valid", int'(bus.be_valid_o), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid_o), 0);
    advance();

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].rv, tbl[n].br, tbl[n].rspv, tbl[n].rr);
      eval_cycle();
      chk($sformatf("tbl%0d_req_ready", n), int'(bus.req_ready_o), int'(tbl[n].x_rdy));
      chk($sformatf("tbl%0d_be_valid", n), int'(bus.be_valid_o), int'(tbl[n].x_bv));
      chk($sformatf("tbl%0d_rsp_valid", n), int'(bus.rsp_valid_o), int'(tbl[n].x_rspv));
      chk($sformatf("tbl%0d_outstanding", n), int'(outstanding), tbl[n].x_out);
      advance();
    end

    // Move prio to 3 so requester 0 would outrank requester 2 without the lock.
    drive(4'b0100, 1, 0, 4'hF); eval_cycle(); advance();
    drive(4'b0000, 0, 1, 4'hF); eval_cycle(); advance();
    for (int c = 0; c < 5; c++) begin
      drive((c >= 2) ? 4'b0101 : 4'b0100, 0, 0, 4'hF);
      eval_cycle();
      chk("lock_be_req", int'(bus.be_req_o), int'(pay[2]));
      chk("lock_req_ready", int'(bus.req_ready_o), 0);
      chk("lock_be_valid", int'(bus.be_valid_o), 1);
      advance();
    end
    drive(4'b0101, 1, 0, 4'hF); eval_cycle();
    chk("lock_accept", int'(bus.req_ready_o), 4'b0100); advance();
    drive(4'b0101, 1, 0, 4'hF); eval_cycle();
    chk("after_lock_grant", int'(bus.req_ready_o), 4'b0001); advance();
    drive(4'b0000, 0, 1, 4'hF); eval_cycle();
    chk("lock_drain0", int'(bus.rsp_valid_o), 4'b0100); advance();
    eval_cycle();
    chk("lock_drain1", int'(bus.rsp_valid_o), 4'b0001); advance();

    // Full FIFO, then completion and pending request in the same cycle.
    for (int c = 0; c < MAXO; c++) begin
      drive(4'b0010, 1, 0, 4'hF); eval_cycle(); advance();
    end
    drive(4'b0010, 1, 0, 4'hF); eval_cycle();
    chk("full_be_valid", int'(bus.be_valid_o), 0);
    chk("full_outstanding", int'(outstanding), 8);
    chk("full_req_ready", int'(bus.req_ready_o), 0);
    advance();
    drive(4'b0010, 1, 1, 4'hF); eval_cycle();
    chk("full_pop_be_valid", int'(bus.be_valid_o), 0);
    chk("full_pop_rsp_valid", int'(bus.rsp_valid_o), 4'b0010);
    chk("full_pop_be_rsp_ready", int'(bus.be_rsp_ready_o), 1);
    advance();
    drive(4'b0010, 1, 0, 4'hF); eval_cycle();
    chk("refill_outstanding", int'(outstanding), 7);
    chk("refill_req_ready", int'(bus.req_ready_o), 4'b0010);
    advance();
    eval_cycle();
    chk("refull_outstanding", int'(outstanding), 8);
    chk("refull_be_valid", int'(bus.be_valid_o), 0);
    advance();
    for (int c = 0; c < MAXO; c++) begin
      drive(4'b0000, 0, 1, 4'hF); eval_cycle(); advance();
    end

    // Completion backpressure with owners 1,3 queued.
    drive(4'b0010, 1, 0, 4'hF); eval_cycle(); advance();
    drive(4'b1000, 1, 0, 4'hF); eval_cycle(); advance();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 0, 1, 4'b1101); eval_cycle();
      chk("bp_rsp_valid", int'(bus.rsp_valid_o), 4'b0010);
      chk("bp_be_rsp_ready", int'(bus.be_rsp_ready_o), 0);
      chk("bp_outstanding", int'(outstanding), 2);
      advance();
    end
    drive(4'b0000, 0, 1, 4'hF); eval_cycle();
    chk("bp_release", int'(bus.be_rsp_ready_o), 1);
    chk("bp_first_owner", int'(bus.rsp_valid_o), 4'b0010);
    advance();
    eval_cycle();
    chk("bp_second_owner", int'(bus.rsp_valid_o), 4'b1000);
    advance();

    // Reset with 3 outstanding and prio = 2.
    for (int c = 0; c < 3; c++) begin
      drive(4'b0010, 1, 0, 4'hF); eval_cycle(); advance();
    end
    drive(4'b0000, 0, 0, 4'hF);
    rst = 1'b1;
    eval_cycle(); advance();
    rst = 1'b0;
    eval_cycle();
    chk("rst_mid_outstanding", int'(outstanding), 0);
    chk("rst_mid_busy", int'(busy), 0);
    advance();
    drive(4'hF, 1, 0, 4'hF); eval_cycle();
    chk("rst_mid_first_grant", int'(bus.req_ready_o), 4'b0001);
    advance();
    drive(4'b0000, 0, 1, 4'hF); eval_cycle(); advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rv = 4'($urandom_range(0, 15));
      if (m_lock >= 0) rv[m_lock] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (i != m_lock) pay[i] = req_t'($urandom_range(0, 255));
      br   = ($urandom_range(0, 3) != 0);
      rspv = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      rr   = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      drive(rv, br, rspv, rr);
      eval_cycle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
